// File: rtl/i2c_fnv_pkg.sv
// Shared types and constants for the I2C FNV-1a hasher target: FSM states,
// command codes and the FNV offset/prime values for 32- and 64-bit digests.
package i2c_fnv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CMD,
    ST_CMD_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_e;

  localparam logic [7:0] CMD_ABSORB = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'h02;

  localparam logic [31:0] FNV32_OFFSET = 32'h811C_9DC5;
  localparam logic [31:0] FNV32_PRIME  = 32'h0100_0193;
  localparam logic [63:0] FNV64_OFFSET = 64'hCBF2_9CE4_8422_2325;
  localparam logic [63:0] FNV64_PRIME  = 64'h0000_0100_0000_01B3;

  // Constants are returned zero-extended to 64 bits; callers slice to width.
  function automatic logic [63:0] fnv_offset(input int width);
    return (width == 64) ? FNV64_OFFSET : {32'h0, FNV32_OFFSET};
  endfunction

  function automatic logic [63:0] fnv_prime(input int width);
    return (width == 64) ? FNV64_PRIME : {32'h0, FNV32_PRIME};
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and derives SCL edge strobes and
// START/STOP strobes from the synchronized levels only.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_q;
  logic       sda_q;
  logic       scl_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes a shift chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda_in};
      scl_q  <= scl_ff[1];
      sda_q  <= sda_ff[1];
    end
  end

  assign scl_s = scl_ff[1];
  assign sda_s = sda_ff[1];

  assign scl_rise  =  scl_s & ~scl_q;
  assign scl_fall  = ~scl_s &  scl_q;
  // SDA may only move while SCL is high for START/STOP, so require SCL high on both samples.
  assign start_det = scl_s & scl_q &  sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q &  sda_s;

endmodule

// File: rtl/i2c_fnv_hasher_target.sv
// I2C target that absorbs written bytes into an FNV-1a digest and streams a
// snapshot of that digest back, MSB byte first, on reads.
module i2c_fnv_hasher_target
  import i2c_fnv_pkg::*;
#(
  parameter int         HASH_WIDTH = 32,
  parameter logic [6:0] I2C_ADDR   = 7'h2A,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_out,
  output logic                  sda_oe,
  output logic [HASH_WIDTH-1:0] hash_out,
  output logic [CNT_WIDTH-1:0]  byte_count,
  output logic                  busy
);

  localparam logic [63:0]           OFFSET_FULL = fnv_offset(HASH_WIDTH);
  localparam logic [63:0]           PRIME_FULL  = fnv_prime(HASH_WIDTH);
  localparam logic [HASH_WIDTH-1:0] OFFSET      = OFFSET_FULL[HASH_WIDTH-1:0];
  localparam logic [HASH_WIDTH-1:0] PRIME       = PRIME_FULL[HASH_WIDTH-1:0];

  state_e state, next_state;

  logic                  sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;
  logic                  rw;
  logic                  ack_on;
  logic                  absorb_en;
  logic [HASH_WIDTH-1:0] hash;
  logic [HASH_WIDTH-1:0] snap;
  logic [7:0]            rx_byte;
  logic [7:0]            tx_byte;
  logic                  tx_bit;
  logic                  byte_done;
  logic                  rx_state;
  logic                  cmd_ok;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign rx_byte   = {shreg[6:0], sda_s};
  assign tx_byte   = snap[HASH_WIDTH-1 -: 8];
  assign tx_bit    = tx_byte[~bit_cnt];
  assign byte_done = scl_rise && (bit_cnt == 3'd7);
  assign rx_state  = (state == ST_ADDR) || (state == ST_CMD) || (state == ST_WDATA);
  assign cmd_ok    = (rx_byte == CMD_ABSORB) || (rx_byte == CMD_RESET);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    if (start_det) begin
      next_state = ST_ADDR;
    end else if (stop_det) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR:
          if (byte_done) next_state = (rx_byte[7:1] == I2C_ADDR) ? ST_ADDR_ACK : ST_IDLE;
        ST_ADDR_ACK:
          if (scl_fall && ack_on) next_state = rw ? ST_RDATA : ST_CMD;
        ST_CMD:
          if (byte_done) next_state = cmd_ok ? ST_CMD_ACK : ST_IDLE;
        ST_CMD_ACK:
          if (scl_fall && ack_on) next_state = ST_WDATA;
        // Data after a reset command is refused rather than silently dropped.
        ST_WDATA:
          if (byte_done) next_state = absorb_en ? ST_WDATA_ACK : ST_IDLE;
        ST_WDATA_ACK:
          if (scl_fall && ack_on) next_state = ST_WDATA;
        ST_RDATA:
          if (scl_fall && (bit_cnt == 3'd7)) next_state = ST_RDATA_ACK;
        ST_RDATA_ACK:
          if (scl_rise && sda_s)        next_state = ST_IDLE;
          else if (scl_fall && ack_on)  next_state = ST_RDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      rw         <= 1'b0;
      ack_on     <= 1'b0;
      absorb_en  <= 1'b0;
      snap       <= OFFSET;
      hash       <= OFFSET;
      byte_count <= '0;
    end else begin
      // Read bits advance on SCL fall so SDA never moves while SCL is high.
      if (start_det || (state != next_state))
        bit_cnt <= '0;
      else if ((scl_rise && rx_state) || (scl_fall && (state == ST_RDATA)))
        bit_cnt <= bit_cnt + 3'd1;

      if (scl_rise && rx_state) shreg <= rx_byte;

      // ack_on marks the second half of an ACK slot: drive phase, or controller ACK seen.
      if (state != next_state)
        ack_on <= 1'b0;
      else if (scl_fall && (state inside {ST_ADDR_ACK, ST_CMD_ACK, ST_WDATA_ACK}))
        ack_on <= 1'b1;
      else if (scl_rise && (state == ST_RDATA_ACK) && !sda_s)
        ack_on <= 1'b1;

      if ((state == ST_ADDR) && (next_state == ST_ADDR_ACK)) begin
        rw   <= rx_byte[0];
        snap <= hash;
      end else if ((state == ST_RDATA_ACK) && (next_state == ST_RDATA)) begin
        snap <= {snap[HASH_WIDTH-9:0], snap[HASH_WIDTH-1 -: 8]};
      end

      if ((state == ST_CMD) && (next_state == ST_CMD_ACK))
        absorb_en <= (rx_byte == CMD_ABSORB);

      if ((state == ST_CMD) && (next_state == ST_CMD_ACK) && (rx_byte == CMD_RESET)) begin
        hash       <= OFFSET;
        byte_count <= '0;
      end else if ((state == ST_WDATA) && (next_state == ST_WDATA_ACK)) begin
        hash <= (hash ^ {{(HASH_WIDTH-8){1'b0}}, rx_byte}) * PRIME;
        if (byte_count != '1) byte_count <= byte_count + CNT_WIDTH'(1);
      end
    end
  end

  // Reset gates the bus outputs combinationally so the line is freed at once.
  always_comb begin
    sda_oe = 1'b0;
    case (state)
      ST_ADDR_ACK, ST_CMD_ACK, ST_WDATA_ACK: sda_oe = ack_on;
      ST_RDATA:                              sda_oe = ~tx_bit;
      default: ;
    endcase
    busy = (state != ST_IDLE) && (state != ST_ADDR);
    if (reset) begin
      sda_oe = 1'b0;
      busy   = 1'b0;
    end
  end

  assign sda_out  = 1'b0;
  assign hash_out = hash;

endmodule

// File: tb/tb_i2c_fnv_hasher_target.sv
// Directed bench: a 32-bit target at 0x2A and a 64-bit target at 0x3A share
// one open-drain bus driven by a bit-banged controller.
module tb_i2c_fnv_hasher_target;

  localparam int Q = 50;

  typedef struct {
    logic [7:0]  data;
    logic [31:0] exp_hash;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        scl;
  logic        sda_m;
  wire         sda_bus;
  logic        oe32, oe64, out32, out64, busy32, busy64;
  logic [31:0] hash32;
  logic [15:0] cnt32;
  logic [63:0] hash64;
  logic [1:0]  cnt64;
  int          n_checks = 0;
  int          n_errors = 0;
  int          oe_cnt = 0;
  vec_t        vecs[4];

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~oe32 & ~oe64;

  i2c_fnv_hasher_target #(.HASH_WIDTH(32), .I2C_ADDR(7'h2A), .CNT_WIDTH(16)) dut32 (
    .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_bus), .sda_out(out32),
    .sda_oe(oe32), .hash_out(hash32), .byte_count(cnt32), .busy(busy32)
  );

  i2c_fnv_hasher_target #(.HASH_WIDTH(64), .I2C_ADDR(7'h3A), .CNT_WIDTH(2)) dut64 (
    .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_bus), .sda_out(out64),
    .sda_oe(oe64), .hash_out(hash64), .byte_count(cnt64), .busy(busy64)
  );

  always @(posedge clk) if (oe32 | oe64) oe_cnt <= oe_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b1; #Q;
    #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    b = sda_bus; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic nack;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(nack);
    ack = ~nack;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) read_bit(b[i]);
    write_bit(~ack);
  endtask

  // Full write transaction; acks counts acknowledged bytes including the address.
  task automatic write_txn(input logic [6:0] addr, input int n, input logic [63:0] data,
                           output int acks);
    logic a;
    bus_start();
    write_byte({addr, 1'b0}, a);
    acks = a ? 1 : 0;
    for (int i = 0; i < n && a; i++) begin
      write_byte(data[8*(n-1-i) +: 8], a);
      if (a) acks++;
    end
    bus_stop();
  endtask

  // Read after a START already on the bus; the last byte is NACKed, then STOP.
  task automatic read_body(input logic [6:0] addr, input int n, output logic [63:0] data,
                           output logic ack);
    logic a;
    logic [7:0] b;
    data = '0;
    write_byte({addr, 1'b1}, a);
    ack = a;
    for (int i = 0; i < n && a; i++) begin
      read_byte(b, i != n - 1);
      data = {data[55:0], b};
    end
    bus_stop();
  endtask

  initial begin
    int          acks;
    int          oe_before;
    logic        ack;
    logic [63:0] rd;

    vecs[0] = '{data: 8'h62, exp_hash: 32'hE70C2DE5};
    vecs[1] = '{data: 8'h63, exp_hash: 32'hE60C2C52};
    vecs[2] = '{data: 8'h00, exp_hash: 32'h050C5D1F};
    vecs[3] = '{data: 8'h61, exp_hash: 32'hE40C292C};

    scl = 1'b1; sda_m = 1'b1; reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    check("rst_hash32", hash32, 32'h811C9DC5);
    check("rst_cnt32", cnt32, 0);
    check("rst_busy32", busy32, 0);
    check("rst_oe32", oe32, 0);
    check("rst_out32", out32, 0);
    check("rst_hash64", hash64, 64'hCBF29CE484222325);
    check("rst_cnt64", cnt64, 0);
    check("rst_out64", out64, 0);

    // Read the offset basis.
    bus_start();
    read_body(7'h2A, 4, rd, ack);
    check("rd_offset_ack", ack, 1);
    check("rd_offset_data", rd[31:0], 32'h811C9DC5);
    check("rd_offset_cnt", cnt32, 0);
    check("rd_offset_busy", busy32, 0);

    // Single-byte absorbs from a freshly reset digest.
    for (int i = 0; i < 4; i++) begin
      write_txn(7'h2A, 1, 64'h02, acks);
      check("vec_rst_acks", acks, 2);
      check("vec_rst_hash", hash32, 32'h811C9DC5);
      check("vec_rst_cnt", cnt32, 0);
      write_txn(7'h2A, 2, {48'h0, 8'h01, vecs[i].data}, acks);
      check("vec_abs_acks", acks, 3);
      check("vec_abs_hash", hash32, vecs[i].exp_hash);
      check("vec_abs_cnt", cnt32, 1);
    end

    // Absorb command then repeated START into a read: no absorb, snapshot read.
    bus_start();
    write_byte({7'h2A, 1'b0}, ack);
    write_byte(8'h01, ack);
    check("rs_cmd_ack", ack, 1);
    check("rs_busy", busy32, 1);
    bus_start();
    read_body(7'h2A, 4, rd, ack);
    check("rs_rd_ack", ack, 1);
    check("rs_rd_data", rd[31:0], 32'hE40C292C);
    check("rs_cnt", cnt32, 1);

    // Unknown command is NACKed and leaves the digest alone.
    write_txn(7'h2A, 1, 64'h05, acks);
    check("badcmd_acks", acks, 1);
    check("badcmd_hash", hash32, 32'hE40C292C);

    // Wrong address: no ACK and SDA never pulled.
    oe_before = oe_cnt;
    write_txn(7'h2B, 2, 64'h0161, acks);
    check("badaddr_acks", acks, 0);
    check("badaddr_oe", oe_cnt - oe_before, 0);
    check("badaddr_hash", hash32, 32'hE40C292C);
    check("badaddr_cnt", cnt32, 1);

    // STOP four bits into a data byte discards it.
    bus_start();
    write_byte({7'h2A, 1'b0}, ack);
    write_byte(8'h01, ack);
    for (int i = 0; i < 4; i++) write_bit(i[0]);
    check("partial_busy_mid", busy32, 1);
    bus_stop();
    check("partial_hash", hash32, 32'hE40C292C);
    check("partial_cnt", cnt32, 1);
    check("partial_busy", busy32, 0);

    // Multi-byte absorb, reset command, then a 6-byte read that wraps.
    write_txn(7'h2A, 3, 64'h016162, acks);
    check("multi_acks", acks, 4);
    check("multi_cnt", cnt32, 3);
    write_txn(7'h2A, 1, 64'h02, acks);
    check("reset_cmd_hash", hash32, 32'h811C9DC5);
    check("reset_cmd_cnt", cnt32, 0);
    bus_start();
    read_body(7'h2A, 6, rd, ack);
    check("wrap_ack", ack, 1);
    check("wrap_data", rd[47:0], 48'h811C9DC5811C);

    // 64-bit target: absorb "a", read 8 bytes, then saturate the 2-bit counter.
    write_txn(7'h3A, 2, 64'h0161, acks);
    check("h64_acks", acks, 3);
    check("h64_hash", hash64, 64'hAF63DC4C8601EC8C);
    check("h64_cnt", cnt64, 1);
    check("h64_other_hash", hash32, 32'h811C9DC5);
    bus_start();
    read_body(7'h3A, 8, rd, ack);
    check("h64_rd_ack", ack, 1);
    check("h64_rd_data", rd, 64'hAF63DC4C8601EC8C);
    write_txn(7'h3A, 4, 64'h01616161, acks);
    check("h64_sat_acks", acks, 5);
    check("h64_sat_cnt", cnt64, 2'b11);

    // Reset while the 32-bit target drives its address ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b1 : ((7'h2A >> (i - 1)) & 1'b1));
    check("abort_oe_pre", oe32, 1);
    reset = 1'b1;
    #1;
    check("abort_oe", oe32, 0);
    check("abort_busy", busy32, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_hash64", hash64, 64'hCBF29CE484222325);
    check("abort_cnt64", cnt64, 0);
    bus_stop();
    bus_start();
    read_body(7'h2A, 4, rd, ack);
    check("post_abort_ack", ack, 1);
    check("post_abort_data", rd[31:0], 32'h811C9DC5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_fnv_hasher_target.md
I2C_FNV_HASHER_TARGET -- requirements
Module: i2c_fnv_hasher_target

Interface
REQ-001 Parameter HASH_WIDTH, default 32, meaning FNV-1a digest width; legal values 32 or 64 only.
REQ-002 Parameter I2C_ADDR, default 7'h2A, meaning 7-bit target address.
REQ-003 Parameter CNT_WIDTH, default 16, meaning width of the absorbed-byte counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 scl  input  1  I2C SCL, asynchronous to clk.
REQ-007 sda_in  input  1  I2C SDA read channel, asynchronous to clk.
REQ-008 sda_out  output  1  SDA write channel; constant 0 (open-drain).
REQ-009 sda_oe  output  1  high = pull SDA low.
REQ-010 hash_out  output  HASH_WIDTH  current digest.
REQ-011 byte_count  output  CNT_WIDTH  bytes absorbed since last hash reset; saturates at all-ones.
REQ-012 busy  output  1  high from address match until STOP or NACKed read.

Function
REQ-013 scl and sda_in shall pass through 2-flop synchronizers; edges and START/STOP are detected on the synchronized signals only.
REQ-014 START = SDA fall while SCL high; STOP = SDA rise while SCL high; both recognized in any state, START also as repeated start.
REQ-015 FSM states: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-016 START -> ADDR; 8 bits sampled on SCL rise, MSB first; match of address -> ADDR_ACK, mismatch -> IDLE without driving SDA.
REQ-017 ACK: sda_oe asserted on the first SCL fall after the 8th bit, released on the following SCL fall.
REQ-018 Write (R/W=0): first byte is the command -> CMD_ACK; 0x01 = absorb, following bytes -> WDATA; 0x02 = reset hash and byte_count to offset basis/0 in the cycle after the command byte completes; other codes are NACKed -> IDLE.
REQ-019 Absorb: per completed data byte b, hash <= (hash XOR b) * PRIME mod 2^HASH_WIDTH, applied in a single cycle after the 8th SCL rise; byte_count increments.
REQ-020 Read (R/W=1): digest snapshotted at address ACK; bytes sent MSB byte first, bit changes on SCL fall; after HASH_WIDTH/8 bytes the index wraps to the MSB byte.
REQ-021 Controller ACK in RDATA_ACK -> next byte; NACK -> IDLE and sda_oe released.
REQ-022 STOP mid-byte shall discard the partial byte (no hash update) and go to IDLE.
REQ-023 Hash updates occurring during a read cannot happen (single port); snapshot guarantees stable read data across a repeated start.

Reset
REQ-024 On reset: FSM IDLE, sda_oe 0, sda_out 0, busy 0, hash_out = OFFSET basis (32: 0x811C9DC5; 64: 0xCBF29CE484222325), byte_count 0, synchronizers 1.
REQ-025 reset asserted mid-transaction aborts immediately; the bus is released in the same cycle.

Structure
REQ-026 Package i2c_fnv_pkg holds FSM state enum, command codes, FNV offset/prime constants for 32 and 64 bits.
REQ-027 One sub-module i2c_bus_sync: synchronizers, SCL rise/fall strobes, START/STOP strobes.

Verification
REQ-028 Reset, read 4 bytes (HASH_WIDTH=32) -> 0x81,0x1C,0x9D,0xC5; byte_count 0.
REQ-029 Write cmd 0x01 + "a" (0x61), read -> 0xE40C292C; byte_count 1.
REQ-030 HASH_WIDTH=64, write 0x01,0x61, read 8 bytes -> 0xAF63DC4C8601EC8C.
REQ-031 Address 0x2B -> no ACK, sda_oe never asserted, hash unchanged.
REQ-032 Write 0x02 after absorbs -> digest returns to offset basis, byte_count 0; read 6 bytes (32-bit) -> wraps to 0x81,0x1C.
REQ-033 STOP after 4 bits of a data byte -> hash and byte_count unchanged, FSM IDLE, busy 0.
